// File: rtl/hazard3_riscv_timer_mc.sv
// Multi-channel RISC-V machine timer with a shared 64-bit mtime and N_CMP mtimecmp channels.
// Includes a tick prescaler, an optional NRZ tick synchroniser and an APB slave with a tear-free mtime read.
module hazard3_riscv_timer_mc #(
    parameter int N_CMP       = 2,
    parameter int PRESCALE_W  = 8,
    parameter int TICK_IS_NRZ = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [15:0]      paddr,
    input  logic             psel,
    input  logic             penable,
    input  logic             pwrite,
    input  logic [31:0]      pwdata,
    output logic [31:0]      prdata,
    output logic             pready,
    output logic             pslverr,
    input  logic             dbg_halt,
    input  logic             tick,
    output logic [N_CMP-1:0] timer_irq
);

    localparam logic [15:0] ADDR_CTRL     = 16'h0000;
    localparam logic [15:0] ADDR_PRESCALE = 16'h0004;
    localparam logic [15:0] ADDR_MTIME    = 16'h0008;
    localparam logic [15:0] ADDR_MTIMEH   = 16'h000C;
    localparam logic [PRESCALE_W-1:0] PCNT_ONE = PRESCALE_W'(1);

    function automatic logic [15:0] cmp_lo_addr(input int idx);
        return 16'(16 + 8 * idx);
    endfunction

    function automatic logic [15:0] cmp_hi_addr(input int idx);
        return 16'(20 + 8 * idx);
    endfunction

    logic                  en_q, en_d;
    logic [PRESCALE_W-1:0] div_q, div_d;
    logic [PRESCALE_W-1:0] pcnt_q, pcnt_d;
    logic [63:0]           mtime_q, mtime_d;
    logic [31:0]           snap_q, snap_d;
    logic [63:0]           cmp_q [N_CMP];
    logic [63:0]           cmp_d [N_CMP];
    logic [N_CMP-1:0]      irq_q, irq_d;

    logic bus_wr;
    logic bus_rd;
    logic tick_evt;
    logic advance;
    logic inc;
    logic [31:0] rdata;

    assign bus_wr  = psel & penable & pwrite;
    assign bus_rd  = psel & penable & ~pwrite;
    assign pready  = 1'b1;
    assign pslverr = 1'b0;

    // NRZ mode: two-flop synchroniser plus a history flop, every edge is one event.
    generate
        if (TICK_IS_NRZ != 0) begin : g_nrz
            logic [2:0] sync_q, sync_d;

            always_comb begin
                sync_d = {sync_q[1], sync_q[0], tick};
            end

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    sync_q <= 3'b000;
                end else begin
                    sync_q <= sync_d;
                end
            end

            assign tick_evt = sync_q[1] ^ sync_q[2];
        end else begin : g_level
            assign tick_evt = tick;
        end
    endgenerate

    assign advance = tick_evt & en_q & ~dbg_halt;

    always_comb begin
        rdata = '0;
        if (paddr == ADDR_CTRL) begin
            rdata[0] = en_q;
        end else if (paddr == ADDR_PRESCALE) begin
            rdata[PRESCALE_W-1:0] = div_q;
        end else if (paddr == ADDR_MTIME) begin
            rdata = mtime_q[31:0];
        end else if (paddr == ADDR_MTIMEH) begin
            rdata = snap_q;
        end else begin
            for (int i = 0; i < N_CMP; i++) begin
                if (paddr == cmp_lo_addr(i)) begin
                    rdata = cmp_q[i][31:0];
                end
                if (paddr == cmp_hi_addr(i)) begin
                    rdata = cmp_q[i][63:32];
                end
            end
        end
    end

    assign prdata = rdata;

    always_comb begin
        en_d    = en_q;
        div_d   = div_q;
        pcnt_d  = pcnt_q;
        mtime_d = mtime_q;
        snap_d  = snap_q;
        cmp_d   = cmp_q;
        irq_d   = '0;
        inc     = 1'b0;

        for (int i = 0; i < N_CMP; i++) begin
            irq_d[i] = (mtime_q >= cmp_q[i]);
        end

        if (bus_wr && paddr == ADDR_CTRL) begin
            en_d = pwdata[0];
        end

        // A PRESCALE write restarts the divider; an event landing on that cycle is dropped.
        if (bus_wr && paddr == ADDR_PRESCALE) begin
            div_d  = pwdata[PRESCALE_W-1:0];
            pcnt_d = '0;
        end else if (advance) begin
            if (pcnt_q == div_q) begin
                inc    = 1'b1;
                pcnt_d = '0;
            end else begin
                pcnt_d = pcnt_q + PCNT_ONE;
            end
        end

        if (bus_wr && paddr == ADDR_MTIME) begin
            mtime_d[31:0] = pwdata;
        end else if (bus_wr && paddr == ADDR_MTIMEH) begin
            mtime_d[63:32] = pwdata;
        end else if (inc) begin
            mtime_d = mtime_q + 64'd1;
        end

        if (bus_rd && paddr == ADDR_MTIME) begin
            snap_d = mtime_q[63:32];
        end

        for (int i = 0; i < N_CMP; i++) begin
            if (bus_wr && paddr == cmp_lo_addr(i)) begin
                cmp_d[i][31:0] = pwdata;
            end
            if (bus_wr && paddr == cmp_hi_addr(i)) begin
                cmp_d[i][63:32] = pwdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            en_q    <= 1'b1;
            div_q   <= '0;
            pcnt_q  <= '0;
            mtime_q <= '0;
            snap_q  <= '0;
            irq_q   <= '0;
            for (int i = 0; i < N_CMP; i++) begin
                cmp_q[i] <= '1;
            end
        end else begin
            en_q    <= en_d;
            div_q   <= div_d;
            pcnt_q  <= pcnt_d;
            mtime_q <= mtime_d;
            snap_q  <= snap_d;
            irq_q   <= irq_d;
            cmp_q   <= cmp_d;
        end
    end

    assign timer_irq = irq_q;

endmodule

// File: tb/tb_hazard3_riscv_timer_mc.sv
// Bench for hazard3_riscv_timer_mc: a level-tick instance and an NRZ-tick instance on one APB bus,
// checked every cycle against a behavioural model plus directed literal expectations.
module tb_hazard3_riscv_timer_mc;
    localparam int NC = 2;
    localparam int PW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [15:0] paddr;
    logic        psel, penable, pwrite;
    logic [31:0] pwdata;
    logic        dbg_halt;
    logic        tick0, tick1;
    logic [31:0] prdata0, prdata1;
    logic        pready0, pready1, pslverr0, pslverr1;
    logic [NC-1:0] irq0, irq1;

    hazard3_riscv_timer_mc #(.N_CMP(NC), .PRESCALE_W(PW), .TICK_IS_NRZ(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .paddr(paddr), .psel(psel), .penable(penable),
        .pwrite(pwrite), .pwdata(pwdata), .prdata(prdata0), .pready(pready0),
        .pslverr(pslverr0), .dbg_halt(dbg_halt), .tick(tick0), .timer_irq(irq0)
    );

    hazard3_riscv_timer_mc #(.N_CMP(NC), .PRESCALE_W(PW), .TICK_IS_NRZ(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .paddr(paddr), .psel(psel), .penable(penable),
        .pwrite(pwrite), .pwdata(pwdata), .prdata(prdata1), .pready(pready1),
        .pslverr(pslverr1), .dbg_halt(dbg_halt), .tick(tick1), .timer_irq(irq1)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model, one slot per instance (0 = level tick, 1 = NRZ tick).
    logic [63:0]   m_mtime [2];
    logic [63:0]   m_cmp   [2][NC];
    logic          m_en    [2];
    logic [PW-1:0] m_div   [2];
    logic [PW-1:0] m_pcnt  [2];
    logic [31:0]   m_snap  [2];
    logic [NC-1:0] m_irq   [2];
    logic [2:0]    m_hist;   // tick1 as sampled 1, 2 and 3 edges ago

    function automatic logic [31:0] m_read(input int d, input logic [15:0] a);
        if (a == 16'h0) return {31'b0, m_en[d]};
        if (a == 16'h4) return 32'(m_div[d]);
        if (a == 16'h8) return m_mtime[d][31:0];
        if (a == 16'hC) return m_snap[d];
        for (int i = 0; i < NC; i++) begin
            if (a == 16'(16 + 8 * i)) return m_cmp[d][i][31:0];
            if (a == 16'(20 + 8 * i)) return m_cmp[d][i][63:32];
        end
        return 32'h0;
    endfunction

    always @(posedge clk) begin
        bit wr, rd, ev, inc;
        wr = psel && penable && pwrite;
        rd = psel && penable && !pwrite;
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                m_mtime[d] = 64'h0;
                m_en[d]    = 1'b1;
                m_div[d]   = '0;
                m_pcnt[d]  = '0;
                m_snap[d]  = 32'h0;
                m_irq[d]   = '0;
                for (int i = 0; i < NC; i++) m_cmp[d][i] = '1;
            end else begin
                ev  = (d == 0) ? tick0 : (m_hist[1] ^ m_hist[2]);
                inc = 1'b0;
                for (int i = 0; i < NC; i++) m_irq[d][i] = (m_mtime[d] >= m_cmp[d][i]);
                if (wr && paddr == 16'h4) begin
                    m_div[d]  = pwdata[PW-1:0];
                    m_pcnt[d] = '0;
                end else if (ev && m_en[d] && !dbg_halt) begin
                    if (m_pcnt[d] == m_div[d]) begin
                        inc = 1'b1;
                        m_pcnt[d] = '0;
                    end else begin
                        m_pcnt[d] = m_pcnt[d] + 1;
                    end
                end
                if (rd && paddr == 16'h8) m_snap[d] = m_mtime[d][63:32];
                if (wr && paddr == 16'h8)      m_mtime[d][31:0]  = pwdata;
                else if (wr && paddr == 16'hC) m_mtime[d][63:32] = pwdata;
                else if (inc)                  m_mtime[d] = m_mtime[d] + 64'd1;
                if (wr && paddr == 16'h0) m_en[d] = pwdata[0];
                for (int i = 0; i < NC; i++) begin
                    if (wr && paddr == 16'(16 + 8 * i)) m_cmp[d][i][31:0]  = pwdata;
                    if (wr && paddr == 16'(20 + 8 * i)) m_cmp[d][i][63:32] = pwdata;
                end
            end
        end
        m_hist = rst_n ? {m_hist[1:0], tick1} : 3'b000;
        #1;
        check("irq_lvl",    64'(irq0),    64'(m_irq[0]));
        check("irq_nrz",    64'(irq1),    64'(m_irq[1]));
        check("prdata_lvl", 64'(prdata0), 64'(m_read(0, paddr)));
        check("prdata_nrz", 64'(prdata1), 64'(m_read(1, paddr)));
        check("pready_pslverr", {62'b0, pready0 & pready1, pslverr0 | pslverr1}, 64'h2);
    end

    task automatic apb_write(input logic [15:0] a, input logic [31:0] d);
        @(negedge clk);
        paddr = a; pwdata = d; pwrite = 1'b1; psel = 1'b1; penable = 1'b0;
        @(negedge clk);
        penable = 1'b1;
        @(negedge clk);
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic apb_read(input logic [15:0] a, output logic [31:0] r0, output logic [31:0] r1);
        @(negedge clk);
        paddr = a; pwrite = 1'b0; psel = 1'b1; penable = 1'b0;
        @(negedge clk);
        penable = 1'b1;
        #1;
        r0 = prdata0;
        r1 = prdata1;
        @(negedge clk);
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic tick0_cycles(input int n);
        tick0 = 1'b1;
        repeat (n) @(negedge clk);
        tick0 = 1'b0;
    endtask

    logic [31:0] r0, r1;
    logic [15:0] addr_list [14] = '{16'h00, 16'h04, 16'h08, 16'h0C, 16'h10, 16'h14, 16'h18,
                                   16'h1C, 16'h20, 16'h24, 16'h28, 16'h2C, 16'h30, 16'h100};

    initial begin
        rst_n = 1'b0; paddr = 16'h0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        pwdata = 32'h0; dbg_halt = 1'b0; tick0 = 1'b0; tick1 = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // reset state
        check("rst_irq0", 64'(irq0), 64'h0);
        check("rst_irq1", 64'(irq1), 64'h0);
        apb_read(16'h00, r0, r1); check("rst_ctrl", {r0, r1}, {32'h1, 32'h1});
        apb_read(16'h04, r0, r1); check("rst_prescale", 64'(r0), 64'h0);
        apb_read(16'h08, r0, r1); check("rst_mtime", {r0, r1}, 64'h0);
        apb_read(16'h10, r0, r1); check("rst_cmp0", 64'(r0), 64'hffffffff);
        apb_read(16'h14, r0, r1); check("rst_cmp0h", 64'(r0), 64'hffffffff);

        // prescaler: div=3, 40 level ticks
        apb_write(16'h04, 32'd3);
        tick0_cycles(40);
        apb_read(16'h08, r0, r1); check("prescale_40", 64'(r0), 64'd10);
        tick0_cycles(2);
        apb_write(16'h04, 32'd3);
        tick0_cycles(3);
        apb_read(16'h08, r0, r1); check("prescale_restart3", 64'(r0), 64'd10);
        tick0_cycles(1);
        apb_read(16'h08, r0, r1); check("prescale_restart4", 64'(r0), 64'd11);

        // tear-free 64-bit read
        apb_write(16'h04, 32'd0);
        apb_write(16'h0C, 32'h0);
        apb_write(16'h08, 32'hffffffff);
        apb_read(16'h08, r0, r1); check("tear_lo", 64'(r0), 64'hffffffff);
        tick0_cycles(3);
        apb_read(16'h0C, r0, r1); check("tear_hi_snap", 64'(r0), 64'h0);
        apb_read(16'h08, r0, r1); check("after_wrap_lo", 64'(r0), 64'h2);
        apb_read(16'h0C, r0, r1); check("after_wrap_hi", 64'(r0), 64'h1);

        // multi-channel irq
        apb_write(16'h08, 32'h0);
        apb_write(16'h0C, 32'h0);
        apb_write(16'h10, 32'd5);
        apb_write(16'h14, 32'd0);
        apb_write(16'h18, 32'd8);
        apb_write(16'h1C, 32'd0);
        tick0_cycles(5);
        check("irq_at_mtime5", 64'(irq0), 64'b00);
        @(negedge clk);
        check("irq0_rise", 64'(irq0), 64'b01);
        tick0_cycles(3);
        check("irq_at_mtime8", 64'(irq0), 64'b01);
        @(negedge clk);
        check("irq1_rise", 64'(irq0), 64'b11);
        apb_write(16'h10, 32'hffffffff);
        check("irq0_hold_write_edge", 64'(irq0), 64'b11);
        @(negedge clk);
        check("irq0_clear", 64'(irq0), 64'b10);

        // write collides with a tick, then freeze
        tick0 = 1'b1;
        apb_write(16'h08, 32'd100);
        tick0 = 1'b0;
        apb_read(16'h08, r0, r1); check("collision", 64'(r0), 64'd100);
        dbg_halt = 1'b1;
        tick0_cycles(20);
        dbg_halt = 1'b0;
        apb_read(16'h08, r0, r1); check("dbg_halt_freeze", 64'(r0), 64'd100);
        apb_write(16'h00, 32'h0);
        tick0_cycles(20);
        apb_read(16'h08, r0, r1); check("ctrl_off_freeze", 64'(r0), 64'd100);
        apb_read(16'h00, r0, r1); check("ctrl_off", 64'(r0), 64'h0);
        apb_write(16'h00, 32'h1);

        // NRZ: each edge increments mtime 3 clk later
        apb_write(16'h08, 32'h0);
        apb_write(16'h0C, 32'h0);
        @(negedge clk);
        paddr = 16'h08;
        for (int k = 1; k <= 6; k++) begin
            tick1 = ~tick1;
            @(posedge clk); #1; check("nrz_edge1", 64'(prdata1), 64'(k - 1));
            @(posedge clk); #1; check("nrz_edge2", 64'(prdata1), 64'(k - 1));
            @(posedge clk); #1; check("nrz_edge3", 64'(prdata1), 64'(k));
            @(negedge clk);
            @(negedge clk);
        end
        apb_read(16'h08, r0, r1); check("nrz_total", 64'(r1), 64'd6);

        // randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            logic [31:0] rv;
            @(negedge clk);
            tick0    = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) tick1 = ~tick1;
            dbg_halt = ($urandom_range(0, 15) == 0);
            rst_n    = ($urandom_range(0, 599) != 0);
            if (psel && !penable) begin
                penable = 1'b1;
            end else if (psel && penable) begin
                psel = 1'b0; penable = 1'b0;
            end else if ($urandom_range(0, 2) == 0) begin
                psel = 1'b1; penable = 1'b0;
                pwrite = 1'($urandom_range(0, 1));
                paddr = addr_list[$urandom_range(0, 13)];
                rv = $urandom();
                case (paddr)
                    16'h00: pwdata = ($urandom_range(0, 5) != 0) ? (rv | 32'h1) : (rv & ~32'h1);
                    16'h04: pwdata = (rv & 32'hffffff00) | 32'($urandom_range(0, 3));
                    16'h08: pwdata = ($urandom_range(0, 3) == 0) ? (32'hfffffff0 | (rv & 32'hf)) : 32'($urandom_range(0, 40));
                    16'h0C, 16'h14, 16'h1C: pwdata = 32'($urandom_range(0, 1));
                    16'h10, 16'h18: pwdata = 32'($urandom_range(0, 60));
                    default: pwdata = rv;
                endcase
            end else begin
                paddr = addr_list[$urandom_range(0, 13)];
            end
        end
        @(negedge clk);
        psel = 1'b0; penable = 1'b0; rst_n = 1'b1;
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
